// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: shifts pattern[len-1:0] out MSB-first for rep+1 passes.
// Define SERIAL_PATTERN_GEN_GAP_EN to insert one idle cycle (GAP) between passes.
module serial_pattern_gen #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   rep,
  input  logic               abort,
  output logic               ready,
  output logic               x,
  output logic               x_valid,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

`ifdef SERIAL_PATTERN_GEN_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t               state, state_next;
  logic [MAX_LEN-1:0]   pat_q, pat_next;
  logic [IDX_W-1:0]     idx_q, idx_next;
  logic [IDX_W-1:0]     last_q, last_next;
  logic [REP_W-1:0]     pass_q, pass_next;
  logic                 x_next, x_valid_next, busy_next, done_next, ready_next;
  logic [IDX_W-1:0]     len_m1;

  // Index of the first bit of a pass; len is clamped to MAX_LEN before use.
  always_comb begin
    if (len >= LEN_W'(MAX_LEN))
      len_m1 = IDX_W'(MAX_LEN - 1);
    else
      len_m1 = IDX_W'(len - LEN_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      pass_q  <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ready   <= 1'b1;
    end else begin
      state   <= state_next;
      pat_q   <= pat_next;
      idx_q   <= idx_next;
      last_q  <= last_next;
      pass_q  <= pass_next;
      x       <= x_next;
      x_valid <= x_valid_next;
      busy    <= busy_next;
      done    <= done_next;
      ready   <= ready_next;
    end
  end

  // Next-state logic also produces the next registered output values, so the
  // bit on x in a cycle is the one idx_q points at during that cycle.
  always_comb begin
    state_next   = state;
    pat_next     = pat_q;
    idx_next     = idx_q;
    last_next    = last_q;
    pass_next    = pass_q;
    x_next       = 1'b0;
    x_valid_next = 1'b0;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    ready_next   = 1'b0;

    case (state)
      IDLE: begin
        ready_next = 1'b1;
        if (start && !abort) begin
          pat_next   = pattern;
          last_next  = len_m1;
          idx_next   = len_m1;
          pass_next  = rep;
          ready_next = 1'b0;
          if (len == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next   = SHIFT;
            x_next       = pattern[len_m1];
            x_valid_next = 1'b1;
            busy_next    = 1'b1;
          end
        end
      end

      SHIFT: begin
        busy_next = 1'b1;
        if (idx_q != '0) begin
          idx_next     = idx_q - IDX_W'(1);
          x_next       = pat_q[idx_next];
          x_valid_next = 1'b1;
        end else if (pass_q != '0) begin
          pass_next = pass_q - REP_W'(1);
          idx_next  = last_q;
`ifdef SERIAL_PATTERN_GEN_GAP_EN
          state_next = GAP;
`else
          x_next       = pat_q[last_q];
          x_valid_next = 1'b1;
`endif
        end else begin
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end

`ifdef SERIAL_PATTERN_GEN_GAP_EN
      GAP: begin
        state_next   = SHIFT;
        busy_next    = 1'b1;
        x_next       = pat_q[idx_q];
        x_valid_next = 1'b1;
      end
`endif

      DONE: begin
        state_next = IDLE;
        ready_next = 1'b1;
      end

      default: begin
        state_next = IDLE;
        ready_next = 1'b1;
      end
    endcase

    // Abort outside IDLE wins over everything and suppresses the done pulse.
    if (abort && state != IDLE) begin
      state_next   = IDLE;
      x_next       = 1'b0;
      x_valid_next = 1'b0;
      busy_next    = 1'b0;
      done_next    = 1'b0;
      ready_next   = 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen: expected bits are queued from a
// reference model at start time and popped as the DUT raises x_valid.
`timescale 1ns/1ps
module tb_serial_pattern_gen;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int REP_W   = 4;
`ifdef SERIAL_PATTERN_GEN_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic               clk = 1'b0;
  logic               reset, start, abort;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [REP_W-1:0]   rep;
  logic               ready, x, x_valid, busy, done;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_q[$];
  int   exp_det;

  logic [7:0] tbl_pat [6] = '{8'h05, 8'h05, 8'hA5, 8'hA5, 8'h01, 8'hC6};
  int         tbl_len [6] = '{4, 4, 0, 12, 1, 8};
  int         tbl_rep [6] = '{0, 2, 3, 0, 15, 1};

  always #5 clk = ~clk;

  serial_pattern_gen #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .rep(rep), .abort(abort), .ready(ready), .x(x), .x_valid(x_valid),
    .busy(busy), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int len_eff(input int l);
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction

  // Reference model: expected {ready, busy, x_valid, done} in cycle c after start.
  function automatic logic [3:0] exp_flags(input int c, input int le, input int rp);
    int   dur, per, pos;
    logic v;
    dur = (le == 0) ? 0 : (rp + 1) * le + GAP * rp;
    per = le + GAP;
    pos = c - 1;
    v   = 1'b0;
    if (le != 0 && pos >= 0 && pos < dur) v = ((pos % per) < le);
    return {(c > dur + 1), (c >= 1 && c <= dur), v, (c == dur + 1)};
  endfunction

  task automatic push_expected(input logic [7:0] pat, input int le, input int rp);
    logic [3:0] sh;
    int nb;
    sh = '0;
    nb = 0;
    exp_det = 0;
    for (int p = 0; p <= rp; p++) begin
      for (int i = le - 1; i >= 0; i--) begin
        exp_q.push_back(pat[i]);
        sh = {sh[2:0], pat[i]};
        nb++;
        if (nb >= 4 && sh == 4'b0101) exp_det++;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] f;
    reset = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; len = '0; rep = '0;
    step();
    step();
    f = {ready, busy, x_valid, done};
    n_checks++;
    if (f !== 4'b1000) begin n_fail++; $display("[TB] FAIL reset_flags got %b exp 1000", f); end
    n_checks++;
    if (x !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_x got %b exp 0", x); end
    reset = 1'b0;
    step();
    f = {ready, busy, x_valid, done};
    n_checks++;
    if (f !== 4'b1000) begin n_fail++; $display("[TB] FAIL post_reset_flags got %b exp 1000", f); end
  endtask

  task automatic test_streams();
    int le, dur, det, nb;
    logic [3:0] sh, f, ef;
    logic b;
    for (int t = 0; t < 6; t++) begin
      le  = len_eff(tbl_len[t]);
      dur = (le == 0) ? 0 : (tbl_rep[t] + 1) * le + GAP * tbl_rep[t];
      exp_q.delete();
      push_expected(tbl_pat[t], le, tbl_rep[t]);
      pattern = tbl_pat[t]; len = LEN_W'(tbl_len[t]); rep = REP_W'(tbl_rep[t]); start = 1'b1;
      sh = '0; det = 0; nb = 0;
      for (int c = 1; c <= dur + 3; c++) begin
        step();
        if (c == 1) begin start = 1'b0; pattern = 8'h3C; len = 4'd3; rep = 4'd7; end
        f  = {ready, busy, x_valid, done};
        ef = exp_flags(c, le, tbl_rep[t]);
        n_checks++;
        if (f !== ef) begin n_fail++; $display("[TB] FAIL stream%0d_flags c=%0d got %b exp %b", t, c, f, ef); end
        n_checks++;
        if (x_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_fail++; $display("[TB] FAIL stream%0d_extra_bit c=%0d got %b exp none", t, c, x);
          end else begin
            b = exp_q.pop_front();
            if (x !== b) begin n_fail++; $display("[TB] FAIL stream%0d_bit c=%0d got %b exp %b", t, c, x, b); end
          end
          sh = {sh[2:0], x};
          nb++;
          if (nb >= 4 && sh == 4'b0101) det++;
        end else if (x !== 1'b0) begin
          n_fail++; $display("[TB] FAIL stream%0d_idle_x c=%0d got %b exp 0", t, c, x);
        end
      end
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL stream%0d_missing got %0d bits left exp 0", t, exp_q.size()); end
      n_checks++;
      if (det != exp_det) begin n_fail++; $display("[TB] FAIL stream%0d_detect got %0d exp %0d", t, det, exp_det); end
    end
  endtask

  task automatic test_busy_ignore();
    int dur;
    logic [3:0] f, ef;
    logic b;
    dur = 8 + GAP;
    exp_q.delete();
    push_expected(8'h05, 4, 1);
    pattern = 8'h05; len = 4'd4; rep = 4'd1; start = 1'b1;
    for (int c = 1; c <= dur + 3; c++) begin
      step();
      if (c == 1) start = 1'b0;
      f  = {ready, busy, x_valid, done};
      ef = exp_flags(c, 4, 1);
      n_checks++;
      if (f !== ef) begin n_fail++; $display("[TB] FAIL busy_flags c=%0d got %b exp %b", c, f, ef); end
      if (x_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL busy_extra_bit c=%0d got %b exp none", c, x);
        end else begin
          b = exp_q.pop_front();
          if (x !== b) begin n_fail++; $display("[TB] FAIL busy_bit c=%0d got %b exp %b", c, x, b); end
        end
      end
      if (c == 3) begin start = 1'b1; pattern = 8'hFF; len = 4'd8; rep = 4'd3; end
      if (c == 4) start = 1'b0;
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL busy_missing got %0d bits left exp 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    logic [3:0] f, ef;
    logic b;
    exp_q.delete();
    push_expected(8'h05, 4, 1);
    pattern = 8'h05; len = 4'd4; rep = 4'd1; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) start = 1'b0;
      f  = {ready, busy, x_valid, done};
      ef = exp_flags(c, 4, 1);
      n_checks++;
      if (f !== ef) begin n_fail++; $display("[TB] FAIL abort_pre_flags c=%0d got %b exp %b", c, f, ef); end
      if (x_valid === 1'b1) begin
        b = exp_q.pop_front();
        n_checks++;
        if (x !== b) begin n_fail++; $display("[TB] FAIL abort_pre_bit c=%0d got %b exp %b", c, x, b); end
      end
    end
    abort = 1'b1;
    for (int c = 6; c <= 9; c++) begin
      step();
      abort = 1'b0;
      f = {ready, busy, x_valid, done};
      n_checks++;
      if (f !== 4'b1000 || x !== 1'b0)
        begin n_fail++; $display("[TB] FAIL abort_idle c=%0d got %b/%b exp 1000/0", c, f, x); end
    end
    exp_q.delete();
    start = 1'b1; abort = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      start = 1'b0; abort = 1'b0;
      f = {ready, busy, x_valid, done};
      n_checks++;
      if (f !== 4'b1000) begin n_fail++; $display("[TB] FAIL abort_start_drop c=%0d got %b exp 1000", c, f); end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] f, ef;
    logic b;
    exp_q.delete();
    push_expected(8'h05, 4, 0);
    pattern = 8'h05; len = 4'd4; rep = 4'd0; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 1) start = 1'b0;
      b = exp_q.pop_front();
      n_checks++;
      if (x !== b || x_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_bit c=%0d got %b exp %b", c, x, b); end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    f = {ready, busy, x_valid, done};
    n_checks++;
    if (f !== 4'b1000 || x !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_idle got %b/%b exp 1000/0", f, x); end
    exp_q.delete();
    push_expected(8'h0B, 4, 0);
    pattern = 8'h0B; len = 4'd4; rep = 4'd0; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) start = 1'b0;
      f  = {ready, busy, x_valid, done};
      ef = exp_flags(c, 4, 0);
      n_checks++;
      if (f !== ef) begin n_fail++; $display("[TB] FAIL rst_new_flags c=%0d got %b exp %b", c, f, ef); end
      if (x_valid === 1'b1) begin
        b = exp_q.pop_front();
        n_checks++;
        if (x !== b) begin n_fail++; $display("[TB] FAIL rst_new_bit c=%0d got %b exp %b", c, x, b); end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL rst_new_missing got %0d bits left exp 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_streams();
    test_busy_ignore();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
